// File: rtl/flu_extract_pkg.sv
// Shared constants, helpers and result type for the FrameLinkUnaligned field extractor.
package flu_extract_pkg;

  localparam int DEF_DATA_WIDTH     = 256;
  localparam int DEF_SOP_POS_WIDTH  = 2;
  localparam int DEF_OFFSET_WIDTH   = 10;
  localparam int DEF_EXTRACT_BYTES  = 6;
  localparam int DEF_RES_FIFO_DEPTH = 4;

  function automatic int calc_block_bytes(input int dw, input int spw);
    return dw / 8 / (1 << spw);
  endfunction

  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;
  localparam int BLOCK_BYTES    = calc_block_bytes(DEF_DATA_WIDTH, DEF_SOP_POS_WIDTH);
  localparam int EOP_POS_WIDTH  = $clog2(BYTES_PER_WORD);

  typedef struct packed {
    logic                             vld;
    logic [DEF_EXTRACT_BYTES*8-1:0]   data;
  } ext_result_t;

endpackage

// File: rtl/flu_extract_res_fifo.sv
// First-word-fall-through result FIFO; output reads as zero while empty.
module flu_extract_res_fifo
  import flu_extract_pkg::*;
#(
  parameter int  DEPTH = DEF_RES_FIFO_DEPTH,
  parameter type T     = ext_result_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wr_en_i,
  input  T     wr_data_i,
  input  logic rd_en_i,
  output T     rd_data_o,
  output logic empty_o,
  output logic full_o
);
  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        wr_go, rd_go;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_go     = wr_en_i && !full_o;
  assign rd_go     = rd_en_i && !empty_o;
  assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_go) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_go) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_go) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/flu_extract_nb.sv
// FLU pass-through with a per-frame EXTRACT_BYTES field extractor at a byte OFFSET;
// one {valid, field} result per frame is queued in a FWFT FIFO.
module flu_extract_nb
  import flu_extract_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int SOP_POS_WIDTH  = DEF_SOP_POS_WIDTH,
  parameter int OFFSET_WIDTH   = DEF_OFFSET_WIDTH,
  parameter int EXTRACT_BYTES  = DEF_EXTRACT_BYTES,
  parameter int RES_FIFO_DEPTH = DEF_RES_FIFO_DEPTH
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [DATA_WIDTH-1:0]           RX_DATA,
  input  logic [SOP_POS_WIDTH-1:0]        RX_SOP_POS,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] RX_EOP_POS,
  input  logic                            RX_SOP,
  input  logic                            RX_EOP,
  input  logic                            RX_SRC_RDY,
  output logic                            RX_DST_RDY,
  input  logic [OFFSET_WIDTH-1:0]         OFFSET,
  output logic [DATA_WIDTH-1:0]           TX_DATA,
  output logic [SOP_POS_WIDTH-1:0]        TX_SOP_POS,
  output logic [$clog2(DATA_WIDTH/8)-1:0] TX_EOP_POS,
  output logic                            TX_SOP,
  output logic                            TX_EOP,
  output logic                            TX_SRC_RDY,
  input  logic                            TX_DST_RDY,
  output logic [EXTRACT_BYTES*8-1:0]      EXT_DATA,
  output logic                            EXT_VLD,
  output logic                            EXT_SRC_RDY,
  input  logic                            EXT_DST_RDY
);
  localparam int BPW  = DATA_WIDTH / 8;
  localparam int BB   = calc_block_bytes(DATA_WIDTH, SOP_POS_WIDTH);
  localparam int EPW  = $clog2(BPW);
  localparam int FW   = OFFSET_WIDTH + 1;
  localparam int FMAX = (1 << FW) - 1;

  typedef enum logic {IDLE, IN_FRAME} state_t;
  typedef struct packed {
    logic                         vld;
    logic [EXTRACT_BYTES*8-1:0]   data;
  } res_t;

  state_t                         state_q, state_d;
  logic [FW-1:0]                  fcnt_q, fcnt_d, cur_fcnt, new_fcnt;
  logic [OFFSET_WIDTH-1:0]        off_q, off_d;
  logic [EXTRACT_BYTES-1:0][7:0]  col_q, col_d, cur_col, new_col;
  logic [EXTRACT_BYTES-1:0]       msk_q, msk_d, cur_msk, new_msk;
  logic [BPW-1:0][7:0]            rx_byte;

  logic [DATA_WIDTH-1:0]          tx_data_q;
  logic [SOP_POS_WIDTH-1:0]       tx_sop_pos_q;
  logic [EPW-1:0]                 tx_eop_pos_q;
  logic                           tx_sop_q, tx_eop_q, tx_src_rdy_q;

  logic tx_load, rx_xfer, closing, fifo_full, fifo_empty, wr_en;
  res_t wr_res, rd_res;

  assign rx_byte    = RX_DATA;
  assign tx_load    = !tx_src_rdy_q || TX_DST_RDY;
  assign RX_DST_RDY = tx_load && !fifo_full;
  assign rx_xfer    = RX_SRC_RDY && RX_DST_RDY;

  // EOP of the running frame followed by a new SOP later in the same word.
  assign closing = (state_q == IN_FRAME) && RX_SOP && RX_EOP &&
                   (int'(RX_SOP_POS) * BB > int'(RX_EOP_POS));

  // cur_*: running frame continued by this word; new_*: frame opened by this word's SOP.
  always_comb begin
    int start, chi, nhi, cpos, npos, nxt;
    start = int'(RX_SOP_POS) * BB;
    chi   = RX_EOP ? int'(RX_EOP_POS) : BPW - 1;
    nhi   = (RX_EOP && !closing) ? int'(RX_EOP_POS) : BPW - 1;
    for (int i = 0; i < EXTRACT_BYTES; i++) begin
      cur_col[i] = col_q[i];
      cur_msk[i] = msk_q[i];
      new_col[i] = 8'h00;
      new_msk[i] = 1'b0;
      cpos = int'(off_q) + i - int'(fcnt_q);
      if (cpos >= 0 && cpos <= chi) begin
        cur_col[i] = rx_byte[cpos[EPW-1:0]];
        cur_msk[i] = 1'b1;
      end
      npos = int'(OFFSET) + i + start;
      if (npos <= nhi) begin
        new_col[i] = rx_byte[npos[EPW-1:0]];
        new_msk[i] = 1'b1;
      end
    end
    nxt      = int'(fcnt_q) + BPW;
    cur_fcnt = (nxt > FMAX) ? FW'(FMAX) : FW'(nxt);
    new_fcnt = FW'(BPW - start);
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    off_d   = off_q;
    col_d   = col_q;
    msk_d   = msk_q;
    wr_en   = 1'b0;
    wr_res  = '0;
    if (rx_xfer) begin
      if (RX_SOP) begin
        // An SOP without a closing EOP silently drops the running frame.
        if (closing) begin
          wr_en       = 1'b1;
          wr_res.vld  = &cur_msk;
          wr_res.data = cur_col;
        end
        if (RX_EOP && !closing) begin
          wr_en       = 1'b1;
          wr_res.vld  = &new_msk;
          wr_res.data = new_col;
          state_d     = IDLE;
        end else begin
          state_d = IN_FRAME;
          fcnt_d  = new_fcnt;
          off_d   = OFFSET;
          col_d   = new_col;
          msk_d   = new_msk;
        end
      end else if (state_q == IN_FRAME) begin
        if (RX_EOP) begin
          wr_en       = 1'b1;
          wr_res.vld  = &cur_msk;
          wr_res.data = cur_col;
          state_d     = IDLE;
        end else begin
          fcnt_d = cur_fcnt;
          col_d  = cur_col;
          msk_d  = cur_msk;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      off_q   <= '0;
      col_q   <= '0;
      msk_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      off_q   <= off_d;
      col_q   <= col_d;
      msk_q   <= msk_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tx_src_rdy_q <= 1'b0;
      tx_data_q    <= '0;
      tx_sop_pos_q <= '0;
      tx_eop_pos_q <= '0;
      tx_sop_q     <= 1'b0;
      tx_eop_q     <= 1'b0;
    end else if (tx_load) begin
      tx_src_rdy_q <= rx_xfer;
      if (rx_xfer) begin
        tx_data_q    <= RX_DATA;
        tx_sop_pos_q <= RX_SOP_POS;
        tx_eop_pos_q <= RX_EOP_POS;
        tx_sop_q     <= RX_SOP;
        tx_eop_q     <= RX_EOP;
      end
    end
  end

  assign TX_DATA    = tx_data_q;
  assign TX_SOP_POS = tx_sop_pos_q;
  assign TX_EOP_POS = tx_eop_pos_q;
  assign TX_SOP     = tx_sop_q;
  assign TX_EOP     = tx_eop_q;
  assign TX_SRC_RDY = tx_src_rdy_q;

  flu_extract_res_fifo #(
    .DEPTH (RES_FIFO_DEPTH),
    .T     (res_t)
  ) u_res_fifo (
    .clk_i     (CLK),
    .rst_ni    (RESET),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_res),
    .rd_en_i   (EXT_DST_RDY),
    .rd_data_o (rd_res),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign EXT_SRC_RDY = !fifo_empty;
  assign EXT_DATA    = rd_res.data;
  assign EXT_VLD     = rd_res.vld;

endmodule

// File: tb/tb_flu_extract_nb.sv
// Directed bench for flu_extract_nb: scoreboard of TX words and per-frame field results.
module tb_flu_extract_nb;
  import flu_extract_pkg::*;

  localparam int DW  = DEF_DATA_WIDTH;
  localparam int SPW = DEF_SOP_POS_WIDTH;
  localparam int OW  = DEF_OFFSET_WIDTH;
  localparam int EB  = DEF_EXTRACT_BYTES;
  localparam int BPW = BYTES_PER_WORD;
  localparam int BB  = BLOCK_BYTES;
  localparam int EPW = EOP_POS_WIDTH;

  typedef logic [DW+SPW+EPW+1:0] txw_t;
  typedef logic [EB*8:0]         fld_t;

  logic           CLK, RESET;
  logic [DW-1:0]  RX_DATA;
  logic [SPW-1:0] RX_SOP_POS;
  logic [EPW-1:0] RX_EOP_POS;
  logic           RX_SOP, RX_EOP, RX_SRC_RDY, RX_DST_RDY;
  logic [OW-1:0]  OFFSET;
  logic [DW-1:0]  TX_DATA;
  logic [SPW-1:0] TX_SOP_POS;
  logic [EPW-1:0] TX_EOP_POS;
  logic           TX_SOP, TX_EOP, TX_SRC_RDY, TX_DST_RDY;
  logic [EB*8-1:0] EXT_DATA;
  logic           EXT_VLD, EXT_SRC_RDY, EXT_DST_RDY;

  flu_extract_nb #(
    .DATA_WIDTH(DW), .SOP_POS_WIDTH(SPW), .OFFSET_WIDTH(OW),
    .EXTRACT_BYTES(EB), .RES_FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_DATA(RX_DATA), .RX_SOP_POS(RX_SOP_POS), .RX_EOP_POS(RX_EOP_POS),
    .RX_SOP(RX_SOP), .RX_EOP(RX_EOP), .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
    .OFFSET(OFFSET),
    .TX_DATA(TX_DATA), .TX_SOP_POS(TX_SOP_POS), .TX_EOP_POS(TX_EOP_POS),
    .TX_SOP(TX_SOP), .TX_EOP(TX_EOP), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY),
    .EXT_DATA(EXT_DATA), .EXT_VLD(EXT_VLD), .EXT_SRC_RDY(EXT_SRC_RDY), .EXT_DST_RDY(EXT_DST_RDY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  int   eop_cnt = 0;
  bit   rand_tx = 1'b0;
  bit   sender_done = 1'b0;
  txw_t tx_q[$];
  fld_t ext_q[$];
  fld_t ext_log[$];

  task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame byte k carries (seed + k) mod 256; field byte i is frame byte off+i when present.
  function automatic fld_t model_field(input int len, input int off, input int seed);
    fld_t r;
    r = '0;
    for (int i = 0; i < EB; i++)
      if (off + i < len) r[8*i +: 8] = 8'((seed + off + i) & 255);
    r[EB*8] = (off + EB <= len);
    return r;
  endfunction

  function automatic logic [DW-1:0] make_word(input int w, input int s, input int len, input int seed);
    logic [DW-1:0] d;
    int k;
    for (int j = 0; j < BPW; j++) begin
      k = w * BPW + j - s;
      d[8*j +: 8] = (k >= 0 && k < len) ? 8'((seed + k) & 255) : 8'hEE;
    end
    return d;
  endfunction

  task automatic send_word(input logic [DW-1:0] d, input logic sop, input logic eop,
                           input logic [SPW-1:0] sp, input logic [EPW-1:0] ep, input logic [OW-1:0] off);
    int n;
    n = 0;
    RX_DATA = d; RX_SOP = sop; RX_EOP = eop; RX_SOP_POS = sp; RX_EOP_POS = ep;
    OFFSET = off; RX_SRC_RDY = 1'b1;
    @(negedge CLK);
    while (!RX_DST_RDY && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (!RX_DST_RDY) begin
      n_tests++;
      n_fail++;
      $display("FAIL rx_accept: RX_DST_RDY stayed 0, required 1");
    end else begin
      tx_q.push_back({d, sp, ep, sop, eop});
      if (eop) eop_cnt++;
    end
    @(posedge CLK);
    #1;
    RX_SRC_RDY = 1'b0; RX_SOP = 1'b0; RX_EOP = 1'b0;
  endtask

  task automatic send_frame(input int sp, input int len, input int off, input int seed);
    int s, total, nw;
    s = sp * BB;
    total = s + len;
    nw = (total + BPW - 1) / BPW;
    for (int w = 0; w < nw; w++)
      send_word(make_word(w, s, len, seed), w == 0, w == nw - 1,
                SPW'(sp), EPW'((total - 1) % BPW), OW'(off));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((ext_q.size() != 0 || tx_q.size() != 0) && n < 3000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    n_tests++;
    if (ext_q.size() != 0 || tx_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: pending ext=%0d tx=%0d, required 0 0", name, ext_q.size(), tx_q.size());
    end
  endtask

  initial begin
    TX_DST_RDY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      TX_DST_RDY = rand_tx ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard: every TX and EXT transfer is checked against the queued expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET && TX_SRC_RDY && TX_DST_RDY) begin
        if (tx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_extra: unexpected word %0h, required none", TX_DATA);
        end else
          check("tx_word", {TX_DATA, TX_SOP_POS, TX_EOP_POS, TX_SOP, TX_EOP}, tx_q.pop_front());
      end
      if (RESET && EXT_SRC_RDY && EXT_DST_RDY) begin
        ext_log.push_back({EXT_VLD, EXT_DATA});
        if (ext_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ext_extra: unexpected result %0h, required none", {EXT_VLD, EXT_DATA});
        end else
          check("ext_result", {EXT_VLD, EXT_DATA}, ext_q.pop_front());
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, ebase;
    logic [DW-1:0] w;
    RESET = 1'b0; RX_DATA = '0; RX_SOP_POS = '0; RX_EOP_POS = '0;
    RX_SOP = 1'b0; RX_EOP = 1'b0; RX_SRC_RDY = 1'b0; OFFSET = '0; EXT_DST_RDY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_tx_src_rdy", TX_SRC_RDY, 0);
    check("rst_ext_src_rdy", EXT_SRC_RDY, 0);
    check("rst_tx_sop_eop", {TX_SOP, TX_EOP}, 0);
    check("rst_tx_data", TX_DATA, 0);
    check("rst_ext_data", {EXT_VLD, EXT_DATA}, 0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Aligned field
    ext_q.push_back(model_field(64, 12, 8'h00));
    send_frame(0, 64, 12, 8'h00);
    wait_drain("aligned");
    check("aligned_field", ext_log[$], {1'b1, 48'h11100F0E0D0C});

    // Field spanning a word boundary
    ext_q.push_back(model_field(40, 5, 8'h40));
    send_frame(3, 40, 5, 8'h40);
    wait_drain("spanning");
    check("spanning_field", ext_log[$], {1'b1, 48'h4A4948474645});

    // Short frame, field runs past the end
    ext_q.push_back(model_field(10, 8, 8'h90));
    send_frame(0, 10, 8, 8'h90);
    wait_drain("short");
    check("short_field", ext_log[$], {1'b0, 48'h000000009998});

    // Frame A (52B) ends at byte 19 of the word where frame B starts at block 3
    ext_q.push_back(model_field(52, 0, 8'h20));
    ext_q.push_back(model_field(20, 0, 8'hA0));
    send_word(make_word(0, 0, 52, 8'h20), 1'b1, 1'b0, 2'd0, 5'd31, '0);
    w = make_word(1, 0, 52, 8'h20);
    for (int j = 20; j < BPW; j++) w[8*j +: 8] = 8'hEE;
    for (int j = 24; j < BPW; j++) w[8*j +: 8] = 8'(8'hA0 + j - 24);
    send_word(w, 1'b1, 1'b1, 2'd3, 5'd19, '0);
    w = make_word(1, 24, 20, 8'hA0);
    send_word(w, 1'b0, 1'b1, 2'd0, 5'd11, '0);
    wait_drain("shared");
    check("shared_field_a", ext_log[ext_log.size()-2], {1'b1, 48'h252423222120});
    check("shared_field_b", ext_log[ext_log.size()-1], {1'b1, 48'hA5A4A3A2A1A0});

    // Result backpressure with random TX readiness
    EXT_DST_RDY = 1'b0;
    rand_tx = 1'b1;
    base = eop_cnt;
    ebase = ext_log.size();
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          ext_q.push_back(model_field(40, f, 16 * f + 3));
          send_frame(1, 40, f, 16 * f + 3);
        end
        sender_done = 1'b1;
      end
    join_none
    for (int n = 0; n < 2000 && eop_cnt - base < 4; n++) begin
      @(posedge CLK);
      #1;
    end
    repeat (3) @(negedge CLK);
    check("bp_rx_stall", RX_DST_RDY, 0);
    check("bp_ext_pending", EXT_SRC_RDY, 1);
    repeat (20) @(posedge CLK);
    #1;
    check("bp_eop_count", eop_cnt - base, 4);
    EXT_DST_RDY = 1'b1;
    for (int n = 0; n < 3000 && !sender_done; n++) begin
      @(posedge CLK);
      #1;
    end
    check("bp_sender_done", sender_done, 1);
    wait_drain("backpressure");
    check("bp_result_count", ext_log.size() - ebase, 6);
    rand_tx = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset during word 2 of a 3-word frame
    send_word(make_word(0, 0, 96, 8'h30), 1'b1, 1'b0, 2'd0, 5'd31, '0);
    send_word(make_word(1, 0, 96, 8'h30), 1'b0, 1'b0, 2'd0, 5'd31, '0);
    repeat (3) @(posedge CLK);
    #1;
    RX_DATA = make_word(2, 0, 96, 8'h30); RX_EOP = 1'b1; RX_EOP_POS = 5'd31; RX_SRC_RDY = 1'b1;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("mid_rst_tx_ctrl", {TX_SRC_RDY, TX_SOP, TX_EOP}, 0);
    check("mid_rst_tx_data", {TX_DATA, TX_SOP_POS, TX_EOP_POS}, 0);
    check("mid_rst_ext", {EXT_SRC_RDY, EXT_VLD, EXT_DATA}, 0);
    RX_SRC_RDY = 1'b0; RX_EOP = 1'b0;
    RESET = 1'b1;
    ebase = ext_log.size();
    repeat (5) @(posedge CLK);
    #1;
    check("post_rst_no_result", EXT_SRC_RDY, 0);
    ext_q.push_back(model_field(40, 0, 8'h60));
    send_frame(2, 40, 0, 8'h60);
    wait_drain("post_reset");
    check("post_rst_field", ext_log[$], {1'b1, 48'h656463626160});
    check("post_rst_count", ext_log.size() - ebase, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
